// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: operand/result handshake bundle for seq_chunk_adder.
// Optional macro SEQ_CHUNK_ADDER_SUB_EN adds the Sub request bit.
`timescale 1ns/1ps
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic             Sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    modport master (output in_valid, A, B, Cin, Sub, out_ready,
                    input  in_ready, out_valid, Sum, Cout, Ovf);
    modport slave  (input  in_valid, A, B, Cin, Sub, out_ready,
                    output in_ready, out_valid, Sum, Cout, Ovf);
`else
    modport master (output in_valid, A, B, Cin, out_ready,
                    input  in_ready, out_valid, Sum, Cout, Ovf);
    modport slave  (input  in_valid, A, B, Cin, out_ready,
                    output in_ready, out_valid, Sum, Cout, Ovf);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit add performed CHUNK bits per clock with a
// registered carry between chunks. One operation in flight; valid/ready on
// both sides. Optional macro SEQ_CHUNK_ADDER_SUB_EN enables A - B via Sub.
`timescale 1ns/1ps
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic              clk,
    input logic              rst_n,
    seq_chunk_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_nxt;
    logic [NCH-1:0][CHUNK-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]             cnt;
    logic                      carry, cout_q, ovf_q;
    logic                      accept, last;
    logic [CHUNK-1:0]          a_ch, b_ch, s_ch;
    logic                      c_ch, cmsb;
    logic [WIDTH-1:0]          b_eff;
    logic                      cin_eff;

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (cnt == CW'(NCH - 1));

    // Operand conditioning: subtract is A + ~B + 1
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_eff   = bus.Sub ? ~bus.B : bus.B;
    assign cin_eff = bus.Cin | bus.Sub;
`else
    assign b_eff   = bus.B;
    assign cin_eff = bus.Cin;
`endif

    // One chunk of the add; carry into the chunk MSB recovered from A^B^S
    always_comb begin
        a_ch         = a_q[cnt];
        b_ch         = b_q[cnt];
        {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        cmsb         = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept -> NCH run cycles -> hold result until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture; contents only matter once RUN begins, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.A;
            b_q <= b_eff;
        end
    end

    // Chunk counter, carry chain and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= cin_eff;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_q[cnt] <= s_ch;
                    carry      <= c_ch;
                    if (last) begin
                        cnt    <= '0;
                        cout_q <= c_ch;
                        ovf_q  <= cmsb ^ c_ch;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed table, corner sequences and random ops for
// seq_chunk_adder (32/8 and degenerate 8/8 instances).
`timescale 1ns/1ps
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(32)) bus ();
    seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        string       nm;
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] s;
        logic        co, ov;
    } vec_t;

    vec_t tbl[8];

    // Reference: whole-word arithmetic; signed overflow from operand/result signs
    function automatic logic [33:0] model(input logic [31:0] a, b, input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ci, ov;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
        ov   = (a[31] == bb[31]) && (full[31] != a[31]);
        return {ov, full[32], full[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Present operands and return #1 after the acceptance edge
    task automatic start_op(input logic [31:0] a, b, input logic cin);
        int n;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges from acceptance until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic finish_op();
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("outv_after_hs", 64'(bus.out_valid), 64'd0);
        chk("inrdy_after_hs", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_checked(input string nm, input logic [31:0] a, b, input logic cin,
                               input logic sub, input int stall);
        logic [33:0] e;
        int lat;
        e = model(a, b, cin, sub);
        start_op(a, b, cin);
        wait_done(lat);
        chk({nm, "_lat"}, 64'(lat), 64'd4);
        chk({nm, "_sum"}, 64'(bus.Sum), 64'(e[31:0]));
        chk({nm, "_cout"}, 64'(bus.Cout), 64'(e[32]));
        chk({nm, "_ovf"}, 64'(bus.Ovf), 64'(e[33]));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, {31'd0, bus.out_valid, bus.Sum}, {31'd0, 1'b1, e[31:0]});
        end
        finish_op();
    endtask

    initial begin
        int          lat, bad;
        logic [31:0] ra, rb;
        logic [7:0]  e8s [2];
        logic [7:0]  e8a [2];
        logic [7:0]  e8b [2];
        logic        e8c [2];
        logic        e8o [2];

        tbl[0] = '{"hex",    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[1] = '{"ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{"posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{"negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{"allone", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5] = '{"zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[6] = '{"chunkc", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
        tbl[7] = '{"cinonly",32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        bus.Sub = 1'b0; bus8.Sub = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.Sum), 64'd0);
        chk("rst_cout", 64'(bus.Cout), 64'd0);
        chk("rst_ovf", 64'(bus.Ovf), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].cin);
            chk({tbl[i].nm, "_busy"}, 64'(bus.in_ready), 64'd0);
            wait_done(lat);
            chk({tbl[i].nm, "_lat"}, 64'(lat), 64'd4);
            chk({tbl[i].nm, "_sum"}, 64'(bus.Sum), 64'(tbl[i].s));
            chk({tbl[i].nm, "_cout"}, 64'(bus.Cout), 64'(tbl[i].co));
            chk({tbl[i].nm, "_ovf"}, 64'(bus.Ovf), 64'(tbl[i].ov));
            finish_op();
        end

        // Reset in the middle of RUN discards the operation
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("midrst_outv", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_sum", 64'(bus.Sum), 64'd0);
        chk("midrst_cout", 64'(bus.Cout), 64'd0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) bad++;
        end
        chk("midrst_no_pulse", 64'(bad), 64'd0);

        // Stall in DONE while a second request waits
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_done(lat);
        chk("stall_lat", 64'(lat), 64'd4);
        @(negedge clk);
        bus.A = 32'h0000_0003; bus.B = 32'h0000_0004; bus.Cin = 1'b1; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_sum", 64'(bus.Sum), 64'h2345_6789);
            chk("stall_inrdy", {62'd0, bus.in_ready, bus.out_valid}, 64'd1);
        end
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("stall_hs_inrdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("stall_second_acc", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        chk("stall2_lat", 64'(lat), 64'd4);
        chk("stall2_sum", 64'(bus.Sum), 64'h0000_0008);
        finish_op();

        // Random operations against the model, random DONE stalls
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ~ra;
            run_checked("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
        end

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        bus.Sub = 1'b1;
        start_op(32'd5, 32'd7, 1'b0);
        wait_done(lat);
        chk("sub_sum", 64'(bus.Sum), 64'hFFFF_FFFE);
        chk("sub_cout", 64'(bus.Cout), 64'd0);
        chk("sub_ovf", 64'(bus.Ovf), 64'd0);
        finish_op();
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            run_checked("rndsub", ra, rb, 1'($urandom_range(0, 1)), 1'b1, 0);
        end
        bus.Sub = 1'b0;
`endif

        // Degenerate single-chunk instance: one RUN cycle
        e8a[0] = 8'hC8; e8b[0] = 8'h64; e8s[0] = 8'h2C; e8c[0] = 1'b1; e8o[0] = 1'b0;
        e8a[1] = 8'h7F; e8b[1] = 8'h01; e8s[1] = 8'h80; e8c[1] = 1'b0; e8o[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus8.A = e8a[i]; bus8.B = e8b[i]; bus8.Cin = 1'b0; bus8.in_valid = 1'b1;
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            lat = 0;
            while (!bus8.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
            chk("w8_lat", 64'(lat), 64'd1);
            chk("w8_sum", 64'(bus8.Sum), 64'(e8s[i]));
            chk("w8_cout", 64'(bus8.Cout), 64'(e8c[i]));
            chk("w8_ovf", 64'(bus8.Ovf), 64'(e8o[i]));
            @(negedge clk) bus8.out_ready = 1'b1;
            @(posedge clk); #1;
            bus8.out_ready = 1'b0;
            chk("w8_inrdy", 64'(bus8.in_ready), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
